// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and data bundle for the bit-serial subtractor.
//   master : drives start, in_a, in_b, borrow_in; observes busy, done,
//            diff_out, borrow_out
//   slave  : the subtractor side (inputs/outputs mirrored)
// Clock and reset are plain ports on the design, not part of this bundle.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff_out;
   logic             borrow_out;

   modport master (
      output start, in_a, in_b, borrow_in,
      input  busy, done, diff_out, borrow_out
   );

   modport slave (
      input  start, in_a, in_b, borrow_in,
      output busy, done, diff_out, borrow_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: computes in_a - in_b - borrow_in, LSB
// first, one bit per Clk cycle through a single full-subtractor cell and a
// borrow flop. Operands are captured when start is seen in IDLE; the result
// and final borrow are registered on the last bit and announced with a
// one-cycle done pulse.
//   Clk        : rising-edge clock
//   ClrN       : asynchronous active-low clear
//   bus.start  : request, sampled only in IDLE
//   bus.in_a   : minuend, captured on accepted start
//   bus.in_b   : subtrahend, captured on accepted start
//   bus.borrow_in  : initial borrow, captured on accepted start
//   bus.busy   : high while bits are being shifted
//   bus.done   : one-cycle result-valid pulse
//   bus.diff_out   : difference, held until the next completion
//   bus.borrow_out : final borrow, held with diff_out
// ---------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic               Clk,
   input  logic               ClrN,
   serial_subtractor_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q,      state_d;
   logic [WIDTH-1:0]   a_sr_q,       a_sr_d;
   logic [WIDTH-1:0]   b_sr_q,       b_sr_d;
   logic [WIDTH-1:0]   diff_sr_q,    diff_sr_d;
   logic               bor_q,        bor_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic [WIDTH-1:0]   diff_out_q,   diff_out_d;
   logic               borrow_out_q, borrow_out_d;

   // Full-subtractor cell on the current LSBs
   logic a_bit;
   logic b_bit;
   logic d_bit;
   logic bor_next;

   always_comb begin
      a_bit    = a_sr_q[0];
      b_bit    = b_sr_q[0];
      d_bit    = a_bit ^ b_bit ^ bor_q;
      bor_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor_q);
   end

   always_ff @(posedge Clk or negedge ClrN) begin
      if (!ClrN) begin
         state_q      <= IDLE;
         a_sr_q       <= '0;
         b_sr_q       <= '0;
         diff_sr_q    <= '0;
         bor_q        <= 1'b0;
         cnt_q        <= '0;
         diff_out_q   <= '0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sr_q       <= a_sr_d;
         b_sr_q       <= b_sr_d;
         diff_sr_q    <= diff_sr_d;
         bor_q        <= bor_d;
         cnt_q        <= cnt_d;
         diff_out_q   <= diff_out_d;
         borrow_out_q <= borrow_out_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_sr_d       = a_sr_q;
      b_sr_d       = b_sr_q;
      diff_sr_d    = diff_sr_q;
      bor_d        = bor_q;
      cnt_d        = cnt_q;
      diff_out_d   = diff_out_q;
      borrow_out_d = borrow_out_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sr_d  = bus.in_a;
               b_sr_d  = bus.in_b;
               bor_d   = bus.borrow_in;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
            diff_sr_d = {d_bit, diff_sr_q[WIDTH-1:1]};
            bor_d     = bor_next;
            if (cnt_q == LAST_BIT) begin
               // Last bit: publish the completed word; counter parks here
               // instead of wrapping.
               diff_out_d   = {d_bit, diff_sr_q[WIDTH-1:1]};
               borrow_out_d = bor_next;
               state_d      = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy       = (state_q == SHIFT);
   assign bus.done       = (state_q == DONE);
   assign bus.diff_out   = diff_out_q;
   assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Randomized and directed bench for serial_subtractor at WIDTH=4 and WIDTH=8
// against an arithmetic reference model (a - b - bin mod 2^W, borrow when
// a < b + bin).
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   logic Clk;
   logic ClrN;

   int checks;
   int errors;
   int prev_d[2];
   int prev_b[2];

   serial_subtractor_if #(.WIDTH(4)) if4 ();
   serial_subtractor_if #(.WIDTH(8)) if8 ();

   serial_subtractor #(.WIDTH(4)) dut4 (.Clk(Clk), .ClrN(ClrN), .bus(if4));
   serial_subtractor #(.WIDTH(8)) dut8 (.Clk(Clk), .ClrN(ClrN), .bus(if8));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_diff(input int w, input int a, input int b, input int bin);
      return (a - b - bin) & ((1 << w) - 1);
   endfunction

   function automatic int model_bor(input int w, input int a, input int b, input int bin);
      return (a < b + bin) ? 1 : 0;
   endfunction

   function automatic int busy_of(input int w);
      return (w == 4) ? int'(if4.busy) : int'(if8.busy);
   endfunction
   function automatic int done_of(input int w);
      return (w == 4) ? int'(if4.done) : int'(if8.done);
   endfunction
   function automatic int diff_of(input int w);
      return (w == 4) ? int'(if4.diff_out) : int'(if8.diff_out);
   endfunction
   function automatic int bor_of(input int w);
      return (w == 4) ? int'(if4.borrow_out) : int'(if8.borrow_out);
   endfunction

   task automatic drive(input int w, input int a, input int b, input int bin, input logic st);
      if (w == 4) begin
         if4.in_a      = 4'(a);
         if4.in_b      = 4'(b);
         if4.borrow_in = bin[0];
         if4.start     = st;
      end else begin
         if8.in_a      = 8'(a);
         if8.in_b      = 8'(b);
         if8.borrow_in = bin[0];
         if8.start     = st;
      end
   endtask

   task automatic wait_idle(input int w);
      int n;
      n = 0;
      while ((busy_of(w) != 0 || done_of(w) != 0) && n < 20) begin
         @(posedge Clk); #1;
         n++;
      end
      if (n >= 20) chk("idle_timeout", 1, 0);
   endtask

   // One complete operation with timing, hold and result checks.
   task automatic run_op(input int w, input int a, input int b, input int bin);
      int ed, eb, ix;
      ix = (w == 4) ? 0 : 1;
      wait_idle(w);
      @(negedge Clk);
      drive(w, a, b, bin, 1'b1);
      @(posedge Clk); #1;
      // Scramble the operands after capture; they must have no effect.
      drive(w, int'($urandom), int'($urandom), int'($urandom_range(0, 1)), 1'b0);
      ed = model_diff(w, a, b, bin);
      eb = model_bor(w, a, b, bin);
      chk("busy_after_start", busy_of(w), 1);
      chk("done_after_start", done_of(w), 0);
      for (int i = 1; i <= w; i++) begin
         @(posedge Clk); #1;
         if (i < w) begin
            chk("busy_shift", busy_of(w), 1);
            chk("done_early", done_of(w), 0);
            chk("diff_hold", diff_of(w), prev_d[ix]);
            chk("bor_hold", bor_of(w), prev_b[ix]);
         end else begin
            chk("done_pulse", done_of(w), 1);
            chk("busy_in_done", busy_of(w), 0);
            chk("diff_out", diff_of(w), ed);
            chk("borrow_out", bor_of(w), eb);
         end
      end
      @(posedge Clk); #1;
      chk("done_one_cycle", done_of(w), 0);
      chk("busy_idle", busy_of(w), 0);
      chk("diff_after", diff_of(w), ed);
      prev_d[ix] = ed;
      prev_b[ix] = eb;
   endtask

   initial begin
      int cap_a[3];
      int cap_b[3];
      int cur_d, cur_b, ra, rb, ed;

      checks = 0;
      errors = 0;
      prev_d = '{0, 0};
      prev_b = '{0, 0};
      drive(4, 0, 0, 0, 1'b0);
      drive(8, 0, 0, 0, 1'b0);

      // Reset state, asserted before any clock edge
      ClrN = 1'b0;
      #2;
      chk("rst_busy", busy_of(4), 0);
      chk("rst_done", done_of(4), 0);
      chk("rst_diff", diff_of(4), 0);
      chk("rst_bor", bor_of(4), 0);
      chk("rst_busy8", busy_of(8), 0);
      @(posedge Clk); #1;
      @(negedge Clk);
      ClrN = 1'b1;

      // start=0 keeps the block idle
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         chk("idle_no_start", busy_of(4), 0);
      end

      // Directed WIDTH=4 cases
      run_op(4, 9, 3, 0);
      run_op(4, 3, 9, 0);
      run_op(4, 0, 0, 1);

      // start held high, operands changing every cycle
      wait_idle(4);
      cur_d = prev_d[0];
      cur_b = prev_b[0];
      for (int k = 0; k < 17; k++) begin
         @(negedge Clk);
         ra = int'($urandom_range(0, 15));
         rb = int'($urandom_range(0, 15));
         drive(4, ra, rb, 0, 1'b1);
         if (k % 6 == 0) begin
            cap_a[k / 6] = ra;
            cap_b[k / 6] = rb;
         end
         @(posedge Clk); #1;
         if (k % 6 == 4) begin
            chk("held_done", done_of(4), 1);
            ed = model_diff(4, cap_a[k / 6], cap_b[k / 6], 0);
            cur_d = ed;
            cur_b = model_bor(4, cap_a[k / 6], cap_b[k / 6], 0);
            chk("held_diff", diff_of(4), cur_d);
            chk("held_bor", bor_of(4), cur_b);
         end else begin
            chk("held_no_done", done_of(4), 0);
            chk("held_diff_hold", diff_of(4), cur_d);
         end
      end
      @(negedge Clk);
      drive(4, 0, 0, 0, 1'b0);
      prev_d[0] = cur_d;
      prev_b[0] = cur_b;

      // Asynchronous clear during the second SHIFT cycle
      run_op(4, 9, 3, 0);
      wait_idle(4);
      @(negedge Clk);
      drive(4, 12, 5, 0, 1'b1);
      @(posedge Clk); #1;
      drive(4, 0, 0, 0, 1'b0);
      @(posedge Clk); #3;
      ClrN = 1'b0;
      #1;
      chk("abort_busy", busy_of(4), 0);
      chk("abort_done", done_of(4), 0);
      chk("abort_diff", diff_of(4), 0);
      chk("abort_bor", bor_of(4), 0);
      @(posedge Clk); #1;
      chk("abort_busy_held", busy_of(4), 0);
      @(negedge Clk);
      ClrN = 1'b1;
      prev_d = '{0, 0};
      prev_b = '{0, 0};
      for (int i = 0; i < 6; i++) begin
         @(posedge Clk); #1;
         chk("abort_no_done", done_of(4), 0);
      end
      run_op(4, 7, 2, 0);

      // WIDTH=8 directed and random
      run_op(8, 200, 55, 0);
      run_op(8, 55, 200, 0);
      for (int i = 0; i < 40; i++)
         run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)));

      // WIDTH=4 exhaustive
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int bin = 0; bin < 2; bin++)
               run_op(4, a, b, bin);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
